mcu_stream_sequencer: RTL

- Reads the three per-component 32-bit bitstream FIFOs (Y, Cb, Cr; each a 16-deep synchronous FIFO with 1-cycle registered read) in JPEG MCU order.
- Merges them into a single word stream with valid/ready backpressure for the output packer.
- Block lengths come from the Huffman stages as a side-band pulse when a block's last word has been written into its FIFO.
- Sits between the per-component FIFOs and the byte-stuffing/output stage.

---
 rtl/mcu_seq_pkg.sv | 26 ++
 rtl/blk_len_queue.sv | 49 ++++
 rtl/mcu_stream_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mcu_seq_pkg.sv
// Shared types for the MCU stream sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: channel and FSM phase enums, and the in-flight read tag.
package mcu_seq_pkg;

  localparam int NUM_CH = 3;

  typedef enum logic [1:0] {
    CH_Y  = 2'd0,
    CH_CB = 2'd1,
    CH_CR = 2'd2
  } chan_e;

  typedef enum logic [0:0] {
    PH_WAIT = 1'b0,
    PH_READ = 1'b1
  } phase_e;

  typedef struct packed {
    chan_e chan;
    logic  blk_last;
    logic  mcu_last;
  } tag_t;

endpackage

// File: rtl/blk_len_queue.sv
// Small FIFO of block lengths, one per component channel.
// Latency: a pushed length is visible on dout the next cycle; dout shows the head combinationally.
// Backpressure: none upstream; a push while full is dropped unless a pop happens in the same cycle.
// Ports: push/din write an entry, pop retires the head, full/empty flags, dout = head entry.
module blk_len_queue #(
  parameter int LEN_W    = 7,
  parameter int LQ_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [LEN_W-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [LEN_W-1:0] dout
);

  localparam int PW = $clog2(LQ_DEPTH);

  // Pointers carry an extra MSB so full and empty are distinguishable.
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [LEN_W-1:0] mem [LQ_DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot first.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/mcu_stream_sequencer.sv
// Reads the Y/Cb/Cr bitstream FIFOs in MCU order and merges them into one tagged word stream.
// Latency: 2 cycles from read_req to out_valid (FIFO read register + skid register); 1 word/cycle sustained.
// Backpressure: out_ready low stops read issue once skid (2 entries) plus the in-flight read are full.
// Ports: per-channel FIFO empty/read_req/rdata/rdata_valid and blk_done/blk_len side-band;
//        out_data/out_valid/out_ready stream with out_chan, out_blk_last, out_mcu_last; sticky len_ovf_err.
module mcu_stream_sequencer
  import mcu_seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 7,
  parameter int LQ_DEPTH = 4,
  parameter int Y_BLKS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              y_fifo_empty,
  input  logic              cb_fifo_empty,
  input  logic              cr_fifo_empty,
  output logic              y_read_req,
  output logic              cb_read_req,
  output logic              cr_read_req,
  input  logic [DATA_W-1:0] y_rdata,
  input  logic [DATA_W-1:0] cb_rdata,
  input  logic [DATA_W-1:0] cr_rdata,
  input  logic              y_rdata_valid,
  input  logic              cb_rdata_valid,
  input  logic              cr_rdata_valid,
  input  logic              y_blk_done,
  input  logic              cb_blk_done,
  input  logic              cr_blk_done,
  input  logic [LEN_W-1:0]  y_blk_len,
  input  logic [LEN_W-1:0]  cb_blk_len,
  input  logic [LEN_W-1:0]  cr_blk_len,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_chan,
  output logic              out_blk_last,
  output logic              out_mcu_last,
  output logic              len_ovf_err
);

  localparam int YC_W = $clog2(Y_BLKS) + 1;

  logic [NUM_CH-1:0] fifo_empty, rvld_v, blk_done_v, q_pop, q_full, q_empty;
  logic [LEN_W-1:0]  blk_len_v [NUM_CH];
  logic [LEN_W-1:0]  q_dout    [NUM_CH];
  logic [DATA_W-1:0] rdat_v    [NUM_CH];

  assign fifo_empty = {cr_fifo_empty, cb_fifo_empty, y_fifo_empty};
  assign rvld_v     = {cr_rdata_valid, cb_rdata_valid, y_rdata_valid};
  assign blk_done_v = {cr_blk_done, cb_blk_done, y_blk_done};
  assign blk_len_v[0] = y_blk_len;
  assign blk_len_v[1] = cb_blk_len;
  assign blk_len_v[2] = cr_blk_len;
  assign rdat_v[0]    = y_rdata;
  assign rdat_v[1]    = cb_rdata;
  assign rdat_v[2]    = cr_rdata;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lq
    blk_len_queue #(.LEN_W(LEN_W), .LQ_DEPTH(LQ_DEPTH)) u_lq (
      .clk   (clk),
      .rst   (rst),
      .push  (blk_done_v[c]),
      .din   (blk_len_v[c]),
      .pop   (q_pop[c]),
      .full  (q_full[c]),
      .empty (q_empty[c]),
      .dout  (q_dout[c])
    );
  end

  // FSM, in-flight tag and skid buffer state.
  phase_e            phase;
  chan_e             chan;
  logic [YC_W-1:0]   ycnt;
  logic [LEN_W-1:0]  remaining;
  tag_t              tag;
  logic              inflight;
  logic [DATA_W-1:0] sk_data [2];
  tag_t              sk_tag  [2];
  logic [1:0]        occ;

  logic [LEN_W-1:0]  cur_len;
  logic [2:0]        fill;
  logic              have_blk, wait_pop, issue, last_issue, skip_blk, advance, pop_out, wr;

  // In WAIT the queue head is used as the block length directly, so the first
  // word of a block is requested in the same cycle its length is popped; this
  // keeps back-to-back blocks bubble-free.
  assign cur_len    = (phase == PH_WAIT) ? q_dout[chan] : remaining;
  assign have_blk   = (phase == PH_READ) || !q_empty[chan];
  assign wait_pop   = (phase == PH_WAIT) && !q_empty[chan];
  assign pop_out    = out_valid && out_ready;
  // Words that will occupy the skid buffer after this edge, before a new issue.
  assign fill       = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop_out};
  assign issue      = have_blk && (cur_len != '0) && !fifo_empty[chan] && (fill < 3'd2);
  assign last_issue = issue && (cur_len == LEN_W'(1));
  assign skip_blk   = wait_pop && (cur_len == '0);
  assign advance    = last_issue || skip_blk;
  assign q_pop      = wait_pop ? (NUM_CH'(1) << chan) : '0;
  assign wr         = inflight && rvld_v[tag.chan];

  assign y_read_req  = issue && (chan == CH_Y);
  assign cb_read_req = issue && (chan == CH_CB);
  assign cr_read_req = issue && (chan == CH_CR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= PH_WAIT;
      chan      <= CH_Y;
      ycnt      <= '0;
      remaining <= '0;
      tag       <= tag_t'('0);
      inflight  <= 1'b0;
    end else begin
      if (advance) begin
        phase <= PH_WAIT;
        case (chan)
          CH_Y: begin
            if (ycnt == YC_W'(Y_BLKS - 1)) begin
              ycnt <= '0;
              chan <= CH_CB;
            end else begin
              ycnt <= ycnt + 1'b1;
            end
          end
          CH_CB:   chan <= CH_CR;
          default: chan <= CH_Y;
        endcase
      end else if (wait_pop) begin
        phase <= PH_READ;
      end

      if (wait_pop) begin
        remaining <= issue ? (cur_len - LEN_W'(1)) : cur_len;
      end else if (issue) begin
        remaining <= remaining - LEN_W'(1);
      end

      // At most one read is ever outstanding: FIFO data returns the next cycle.
      if (issue) begin
        tag      <= '{chan: chan, blk_last: last_issue, mcu_last: last_issue && (chan == CH_CR)};
        inflight <= 1'b1;
      end else if (wr) begin
        inflight <= 1'b0;
      end
    end
  end

  // Two-entry in-order skid buffer; entry 0 is the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ        <= '0;
      sk_data[0] <= '0;
      sk_data[1] <= '0;
      sk_tag[0]  <= tag_t'('0);
      sk_tag[1]  <= tag_t'('0);
    end else begin
      case ({pop_out, wr})
        2'b01: begin
          if (occ == 2'd0) begin
            sk_data[0] <= rdat_v[tag.chan];
            sk_tag[0]  <= tag;
          end else begin
            sk_data[1] <= rdat_v[tag.chan];
            sk_tag[1]  <= tag;
          end
          occ <= occ + 2'd1;
        end
        2'b10: begin
          sk_data[0] <= sk_data[1];
          sk_tag[0]  <= sk_tag[1];
          occ        <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            sk_data[0] <= rdat_v[tag.chan];
            sk_tag[0]  <= tag;
          end else begin
            sk_data[0] <= sk_data[1];
            sk_tag[0]  <= sk_tag[1];
            sk_data[1] <= rdat_v[tag.chan];
            sk_tag[1]  <= tag;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_ovf_err <= 1'b0;
    end else if (|(blk_done_v & q_full & ~q_pop)) begin
      len_ovf_err <= 1'b1;
    end
  end

  // Head fields are gated so stale entries never appear on the bus.
  assign out_valid    = (occ != 2'd0);
  assign out_data     = out_valid ? sk_data[0] : '0;
  assign out_chan     = out_valid ? sk_tag[0].chan : CH_Y;
  assign out_blk_last = out_valid && sk_tag[0].blk_last;
  assign out_mcu_last = out_valid && sk_tag[0].mcu_last;

endmodule
